// File: rtl/kfpga_config_loader.sv
// Feeds a byte-wide configuration bitstream into the kFPGA serial config chain,
// LSB first, one bit per clock, and watches the chain tail for stray ones.
module kfpga_config_loader #(
    parameter int unsigned CHAIN_LENGTH = 34688,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  chain_out,
    output logic                  chain_enable,
    output logic                  chain_nreset,
    input  logic                  chain_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int SUM_W = $clog2(CHAIN_LENGTH + DATA_WIDTH + 2);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    state_t                state, next_state;
    logic [CLR_W-1:0]      clear_cnt;
    logic [CNT_W-1:0]      shifted;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [IDX_W-1:0]      bit_idx;
    logic                  buf_valid;

    logic [SUM_W-1:0]      issued;
    logic [SUM_W-1:0]      pending;
    logic                  last_bit;
    logic                  final_bit;
    logic                  accept;
    logic                  shift_now;
    logic                  shift_bit;
    logic                  start_ok;

    // Bits already committed to the chain: counted ones plus the one on the wire now.
    assign issued    = SUM_W'(shifted) + SUM_W'(chain_enable);
    assign pending   = buf_valid ? (SUM_W'(DATA_WIDTH) - SUM_W'(bit_idx)) : '0;
    assign last_bit  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign final_bit = ((issued + SUM_W'(1)) == SUM_W'(CHAIN_LENGTH));
    assign s_ready   = (state == LOAD) && (!buf_valid || last_bit)
                     && ((issued + pending) < SUM_W'(CHAIN_LENGTH));
    assign accept    = s_valid && s_ready;
    // A word arriving into an empty buffer goes straight out as bit 0.
    assign shift_now = (state == LOAD) && (buf_valid || accept);
    assign shift_bit = buf_valid ? buf_data[bit_idx] : s_data[0];
    assign start_ok  = start && !abort && ((state == IDLE) || (state == DONE));

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = CLEAR;
                CLEAR:   if (clear_cnt == CLR_W'(CLEAR_CYCLES - 1)) next_state = LOAD;
                LOAD:    if (issued == SUM_W'(CHAIN_LENGTH)) next_state = DONE;
                DONE:    if (start) next_state = CLEAR;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            clear_cnt    <= '0;
            shifted      <= '0;
            chain_nreset <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state        <= next_state;
            chain_nreset <= (next_state != CLEAR);
            busy         <= (next_state == CLEAR) || (next_state == LOAD);
            done         <= (next_state == DONE);
            clear_cnt    <= (state == CLEAR) ? clear_cnt + CLR_W'(1) : '0;
            shifted      <= (next_state == CLEAR) ? '0 : shifted + CNT_W'(chain_enable);
            if (start_ok) begin
                error <= 1'b0;
            end else if ((state == LOAD) && chain_enable && chain_in) begin
                error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            buf_data     <= '0;
            bit_idx      <= '0;
            buf_valid    <= 1'b0;
            chain_out    <= 1'b0;
            chain_enable <= 1'b0;
        end else if (abort) begin
            buf_valid    <= 1'b0;
            chain_out    <= 1'b0;
            chain_enable <= 1'b0;
        end else begin
            chain_enable <= shift_now;
            chain_out    <= shift_now ? shift_bit : 1'b0;
            if (shift_now) begin
                if (buf_valid) begin
                    if (final_bit) begin
                        buf_valid <= 1'b0;
                    end else if (last_bit) begin
                        buf_valid <= accept;
                        if (accept) begin
                            buf_data <= s_data;
                            bit_idx  <= '0;
                        end
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end else begin
                    buf_data  <= s_data;
                    bit_idx   <= IDX_W'(1);
                    buf_valid <= (DATA_WIDTH > 1) && !final_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Scoreboard bench for kfpga_config_loader: the driver queues the expected chain
// bits of each load, a negedge monitor pops and compares them on every enable.
module tb_kfpga_config_loader;

    localparam int CL = 20;
    localparam int DW = 8;
    localparam int CC = 4;
    localparam int NW = (CL + DW - 1) / DW;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          chain_in = 1'b0;
    logic          s_ready, chain_out, chain_enable, chain_nreset, busy, done, error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit exp_q[$];

    kfpga_config_loader #(.CHAIN_LENGTH(CL), .DATA_WIDTH(DW), .CLEAR_CYCLES(CC)) dut (
        .clock(clock), .nreset(nreset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .chain_out(chain_out), .chain_enable(chain_enable), .chain_nreset(chain_nreset),
        .chain_in(chain_in), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every enabled cycle must carry the next expected chain bit.
    always @(negedge clock) begin
        if (nreset === 1'b1 && chain_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL chain_bit_extra: got bit %0d, expected no further bit", chain_out);
            end else begin
                check("chain_bit", int'(chain_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_chain_out"}, chain_out, 0);
        check({tag, "_chain_enable"}, chain_enable, 0);
        check({tag, "_chain_nreset"}, chain_nreset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // mode 0: fixed words, valid always high; 1: 5-cycle stall mid word 1;
    // 2: random words and random valid; 3: fixed words plus stray start pulses.
    task automatic do_load(input int mode, input int abort_at, input int inject_at);
        logic [DW-1:0] words[NW];
        logic [7:0]    fixed[3];
        int wi, en_cnt, nrst_cnt, acc_cnt, c0, first_en, last_en, stall, done_cyc, gap;
        bit hs, finished, aborted;
        fixed[0] = 8'hA5; fixed[1] = 8'h3C; fixed[2] = 8'h0F;
        for (int i = 0; i < NW; i++) words[i] = (mode == 2) ? DW'($urandom) : fixed[i];
        for (int b = 0; b < CL; b++) exp_q.push_back(words[b / DW][b % DW]);
        wi = 0; en_cnt = 0; nrst_cnt = 0; acc_cnt = 0; first_en = -1; last_en = 0;
        stall = 0; done_cyc = 0; finished = 0; aborted = 0;

        @(posedge clock); #1;
        s_data  = words[0];
        s_valid = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        start   = 1'b1;
        @(negedge clock); c0 = cyc;
        @(posedge clock); #1;
        start = 1'b0;

        for (int t = 0; t < 300 && !finished && !aborted; t++) begin
            @(negedge clock);
            if (t == 0) check("error_cleared_by_start", error, 0);
            if (!chain_nreset) nrst_cnt++;
            if (chain_enable) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
                check("error_flag", error, int'(inject_at >= 0 && en_cnt >= inject_at + 2));
            end
            if (inject_at >= 0 && chain_in) check("inject_hits_enable", chain_enable, 1);
            hs = s_valid && s_ready;
            if (hs) acc_cnt++;
            if (done) begin
                finished = 1;
                done_cyc = cyc;
                check("enable_low_in_done", chain_enable, 0);
                check("busy_low_in_done", busy, 0);
            end else if (abort_at >= 0 && en_cnt >= abort_at) begin
                aborted = 1;
            end else begin
                @(posedge clock); #1;
                if (hs) wi++;
                s_data   = (wi < NW) ? words[wi] : '1;
                chain_in = (inject_at >= 0) && (en_cnt == inject_at);
                start    = (mode == 3) && (t == 1 || en_cnt == 5);
                if (mode == 1 && en_cnt >= 12 && stall < 5) begin
                    s_valid = 1'b0;
                    stall++;
                end else begin
                    s_valid = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end
        end

        if (aborted) begin
            @(posedge clock); #1; abort = 1'b1; start = 1'b1; chain_in = 1'b0;
            @(posedge clock); #1; abort = 1'b0; start = 1'b0;
            @(negedge clock);
            check("abort_busy", busy, 0);
            check("abort_s_ready", s_ready, 0);
            check("abort_chain_enable", chain_enable, 0);
            check("abort_done", done, 0);
            check("abort_chain_nreset", chain_nreset, 1);
            exp_q.delete();
        end else if (!finished) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end else begin
            check("enable_count", en_cnt, CL);
            check("words_accepted", acc_cnt, NW);
            check("nreset_low_cycles", nrst_cnt, CC);
            check("queue_drained", exp_q.size(), 0);
            check("error_at_done", error, int'(inject_at >= 0));
            if (mode == 0 || mode == 3) begin
                check("first_enable_latency", first_en - c0, CC + 2);
                check("start_to_done", done_cyc - c0, CC + CL + 2);
                check("enables_contiguous", last_en - first_en + 1, CL);
            end
            if (mode == 1) begin
                gap = (last_en - first_en + 1) - CL;
                check("stall_gap_within_stall", int'(gap >= 1 && gap <= 5), 1);
            end
        end
        @(posedge clock); #1;
        s_valid  = 1'b0;
        chain_in = 1'b0;
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        @(negedge clock); nreset = 1'b1;
        @(negedge clock);
        check_reset_values("idle");

        do_load(0, -1, -1);   // A5 3C 0F, gapless
        do_load(1, -1, -1);   // stalled stream
        do_load(0, -1, 7);    // integrity error at bit 7
        do_load(0, -1, -1);   // start clears error
        do_load(0, 10, -1);   // abort after 10 bits (start during abort too)
        do_load(0, -1, -1);   // fresh full load after abort
        do_load(3, -1, -1);   // start ignored in CLEAR and LOAD

        // Asynchronous reset while clearing the chain.
        @(posedge clock); #1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #3;
        check("clear_nreset_low", chain_nreset, 0);
        check("clear_busy", busy, 1);
        nreset = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clock); nreset = 1'b1;
        @(negedge clock);
        check("after_reset_idle", busy, 0);

        for (int r = 0; r < 4; r++) do_load(2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kfpga_config_loader.md
# kfpga_config_loader

Upstream feeder for the kFPGA core's serial configuration chain. Accepts a configuration bitstream as bytes over a valid/ready stream and shifts it into the core's `config_in` one bit per clock, LSB of each byte first. It drives `config_enable` and `config_nreset`, and reports busy/done/error. It checks chain integrity by watching the core's `config_out` while loading.

## Interface
Parameters:
- `CHAIN_LENGTH`, default 34688: total configuration bits in the chain.
- `DATA_WIDTH`, default 8: stream word width.
- `CLEAR_CYCLES`, default 4: cycles `config_nreset` is held low before loading; must be ≥ 1.

Ports:
- `clock`  in  1  system clock, all logic rising-edge.
- `nreset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; ignored unless in IDLE or DONE.
- `abort`  in  1  return to IDLE from any state, next cycle.
- `s_data`  in  DATA_WIDTH  bitstream word, bit 0 shifted first.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts word this cycle.
- `chain_out`  out  1  serial bit to core `config_in`.
- `chain_enable`  out  1  to core `config_enable`; core shifts on each clock edge while high.
- `chain_nreset`  out  1  to core `config_nreset`, active-low chain clear.
- `chain_in`  in  1  from core `config_out` (chain tail).
- `busy`  out  1  high in CLEAR or LOAD.
- `done`  out  1  high in DONE.
- `error`  out  1  sticky integrity error; cleared on `start`.

## Operation
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE → CLEAR on `start`. CLEAR drives `chain_nreset`=0 for exactly CLEAR_CYCLES cycles, then goes to LOAD. LOAD → DONE once CHAIN_LENGTH bits have been shifted. DONE → CLEAR on `start`.
- `abort` from any state → IDLE. It deasserts `chain_enable`, drops the buffered word, and leaves the counter value don't-care.
- Word buffer holds one word plus a bit index, 0..DATA_WIDTH-1.
- Bit counter `shifted` has width $clog2(CHAIN_LENGTH+1). It resets to 0 on entry to CLEAR and increments on every cycle that `chain_enable`=1.
- `s_ready` = LOAD && (buffer empty || buffer shifting its last bit this cycle) && (`shifted` + bits still pending in buffer < CHAIN_LENGTH).
  - Result: gapless back-to-back streaming at one bit per clock.
- `chain_enable`=1 on each LOAD cycle where the buffer holds a bit. `chain_out` is that bit. A stalled stream idles `chain_enable`=0 with no bit lost.
- If CHAIN_LENGTH is not a multiple of DATA_WIDTH, the last word's upper unused bits are discarded. No further word is accepted after the last needed bit.
- Integrity check: after CLEAR the chain holds all zeros, so `chain_in` must be 0 on every cycle with `chain_enable`=1 in LOAD. Any 1 sets `error`, which stays set until the next `start`. Loading continues regardless.
- `start` while busy is ignored; `error` is not set by it.
- Simultaneous `start` and `abort`: `abort` wins.

## Timing
- Reset values: state IDLE, `s_ready`=0, `chain_out`=0, `chain_enable`=0, `chain_nreset`=1, `busy`=0, `done`=0, `error`=0. The buffer is empty and `shifted`=0.
- `chain_out`, `chain_enable`, `chain_nreset`, `busy`, `done` and `error` are registered outputs. `s_ready` is combinational from state, buffer and counter.
- `start` at cycle 0: `chain_nreset`=0 in cycles 1..CLEAR_CYCLES; state is LOAD from cycle CLEAR_CYCLES+1.
- The first accepted word in LOAD produces `chain_enable`=1 with its bit 0 on the next cycle.
- With `s_valid` held high, load duration is CLEAR_CYCLES + 1 + CHAIN_LENGTH + 1 cycles from `start` to `done`.
- `done` rises the cycle after the final `chain_enable` pulse. `chain_enable` is 0 in DONE.
- Asynchronous `nreset` mid-load: immediate return to reset values. `chain_nreset` returns to 1; the partially loaded chain is not cleared until the next `start`.

## Test plan
- Use CHAIN_LENGTH=20, DATA_WIDTH=8, CLEAR_CYCLES=4, with `s_valid` always high and words 0xA5, 0x3C, 0x0F. Required:
  - `chain_nreset` low for 4 cycles.
  - 20 consecutive `chain_enable` cycles carrying 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - Upper 4 bits of 0x0F discarded; exactly 3 words accepted; `done`=1 the next cycle.
- Same load with `s_valid` deasserted for 5 cycles mid-word. Required: `chain_enable` low only during the stall, the bit sequence is identical, and no duplicate or missing bit.
- Drive `chain_in`=1 for one enabled cycle at bit 7. Required: `error`=1 from the next cycle through DONE, and the load still completes. A subsequent `start` clears `error`.
- Assert `abort` after 10 bits shifted. Required: IDLE next cycle with `busy`=0 and `s_ready`=0. A fresh `start` re-clears the chain and a full load of 20 bits succeeds.
- Assert `nreset` low asynchronously during CLEAR. Required: all outputs at reset values without a clock edge; `chain_nreset`=1.
- Pulse `start` during LOAD and during CLEAR. Required: no state change and the bit count is unaffected.
